// File: rtl/fft_input_framer.sv
// fft_input_framer: collects N samples into a register buffer at bit-reversed
// addresses, then drains the buffer in natural address order over a
// valid/ready handshake. Loading and draining alternate on a single buffer.
module fft_input_framer #(
   parameter int N  = 8,
   parameter int DW = 8,
   parameter int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic [AW-1:0] out_idx,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          overrun
);

   typedef enum logic {
      LOAD  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] wr_cnt_q, wr_cnt_d;
   logic [AW-1:0] rd_cnt_q, rd_cnt_d;
   logic          overrun_q, overrun_d;
   logic [DW-1:0] mem_q [N];
   logic [DW-1:0] mem_d [N];
   logic [AW-1:0] wr_addr;
   logic          accept;
   logic          xfer;

   // Write address is the load count with its bits mirrored
   generate
      for (genvar gi = 0; gi < AW; gi++) begin : g_bitrev
         assign wr_addr[gi] = wr_cnt_q[AW-1-gi];
      end
   endgenerate

   // Handshake outputs are pure decodes of state gated by the enable
   assign in_ready  = ena && (state_q == LOAD);
   assign out_valid = ena && (state_q == DRAIN);
   assign out_last  = out_valid && (rd_cnt_q == LAST_IDX);
   assign out_idx   = rd_cnt_q;
   assign out_data  = mem_q[rd_cnt_q];
   assign overrun   = overrun_q;

   assign accept = in_valid && in_ready;
   assign xfer   = out_valid && out_ready;

   // Next-state: counters, buffer write, phase changes and sticky overrun
   always_comb begin
      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      overrun_d = overrun_q;
      mem_d     = mem_q;
      if (accept) begin
         mem_d[wr_addr] = in_data;
         wr_cnt_d       = wr_cnt_q + AW'(1);
         if (wr_cnt_q == LAST_IDX) begin
            state_d = DRAIN;
         end
      end
      if (xfer) begin
         rd_cnt_d = rd_cnt_q + AW'(1);
         if (out_last) begin
            state_d = LOAD;
         end
      end
      // A sample offered while draining is dropped and flagged
      if (in_valid && ena && (state_q == DRAIN)) begin
         overrun_d = 1'b1;
      end
   end

   // Control state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= LOAD;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         overrun_q <= overrun_d;
      end
   end

   // One register per buffer entry, cleared by reset so a partial frame is lost
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_mem
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mem_q[gi] <= '0;
            end else begin
               mem_q[gi] <= mem_d[gi];
            end
         end
      end
   endgenerate

endmodule

// File: doc/fft_input_framer.md
# fft_input_framer

Front-end stage of the FFT datapath. It collects a frame of N real 8-bit samples from the pin-level input stream into an internal register buffer, storing each sample at its bit-reversed address. It then streams the frame out in natural address order, which is bit-reversed sample order, to the radix-2 FFT core through a valid/ready handshake. Single-buffered: loading and draining alternate and never overlap.

## Interface
- N, 8, frame length; power of two, legal range 4..16.
- DW, 8, sample width in bits.
- AW, $clog2(N), index width (derived; do not override).

- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  global enable; when 0 all state is frozen.
- in_data  input  DW  incoming sample.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  framer can accept a sample this cycle.
- out_data  output  DW  buffered sample at address out_idx.
- out_idx  output  AW  buffer address being presented (0..N-1).
- out_valid  output  1  out_data/out_idx are valid.
- out_ready  input  1  downstream FFT core accepts this cycle.
- out_last  output  1  high with out_valid on the final word of a frame (out_idx == N-1).
- overrun  output  1  sticky flag: a sample arrived while the framer could not accept it.

## Operation
- State machine has two states, LOAD and DRAIN. The reset state is LOAD.
- An input accept occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- in_ready = ena && (state == LOAD). out_valid = ena && (state == DRAIN). Both are combinational from state.
- LOAD:
  - Each accept writes mem[bitrev(wr_cnt)] <= in_data, then wr_cnt increments.
  - bitrev reverses the AW bits of the count. For N=8 the write order is 0,4,2,6,1,5,3,7.
  - An accept with wr_cnt == N-1 wraps wr_cnt to 0 and moves the state to DRAIN.
- DRAIN:
  - out_idx = rd_cnt, out_data = mem[rd_cnt], out_last = out_valid && (rd_cnt == N-1).
  - Each transfer increments rd_cnt.
  - A transfer with out_last wraps rd_cnt to 0 and moves the state to LOAD.
- Overrun: in_valid && ena && (state == DRAIN) sets overrun = 1. The sample is discarded and buffer contents are unaffected. overrun clears only on reset.
- ena = 0:
  - No accept, no transfer, no counter or state change, overrun not set.
  - Buffer contents are retained.
  - in_ready = out_valid = out_last = 0. out_data and out_idx keep tracking mem[rd_cnt] and rd_cnt.
- Reset, asserted at any time including mid-frame:
  - State returns to LOAD, wr_cnt = rd_cnt = 0, all mem entries = 0, overrun = 0.
  - Any partial frame is discarded.
- Outputs during reset: in_ready = 0 only while ena = 0 (otherwise 1), out_valid = 0, out_last = 0, out_idx = 0, out_data = 0, overrun = 0.
- No arithmetic beyond counters. Counters are AW bits wide and wrap naturally at N.

## Timing
- Accept at edge k of the N-th sample: out_valid = 1 in the cycle after edge k, first word presented with out_idx = 0. Load-to-drain latency is 1 cycle.
- Transfer of the last word at edge m: in_ready = 1 in the cycle after edge m.
- Minimum frame period is 2N cycles: N accepts followed by N transfers with in_valid = out_ready = 1 throughout.
- out_data, out_idx and out_last must hold stable while out_valid && !out_ready.
- Simultaneous in_valid and the final out transfer in the same cycle: the input sample is dropped and overrun is set, because in_ready is 0 in that cycle.
- Gaps in in_valid or out_ready stall the respective counter only. Any gap length is legal.

## Test plan
- Ramp frame (N=8, ena=1, out_ready=1):
  - Stimulus: in_data 0x10..0x17 on consecutive cycles.
  - out_data = 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17 with out_idx 0..7.
  - out_last only on the 8th word; out_valid rises exactly 1 cycle after the 8th accept; in_ready returns the cycle after the last transfer.
- Backpressure:
  - Stimulus: same frame, out_ready toggling 1,0,0,1,...
  - out_data and out_idx are held while stalled; the full sequence arrives without loss or duplication; overrun = 0.
- Overrun:
  - Stimulus: in_valid = 1 with data 0xAA during DRAIN.
  - overrun = 1 from the next cycle and stays high; drained data remains the original frame; the next frame loads correctly.
- ena gating:
  - Stimulus: drop ena for 5 cycles after the 3rd sample while in_valid = 1.
  - in_ready = 0 and no accepts during the gap; after ena returns, the frame completes with correct bit-reversed order and overrun = 0.
- Reset mid-drain:
  - Stimulus: assert rst_n = 0 asynchronously (between edges) after 3 transfers.
  - Immediately out_valid = 0, overrun = 0, out_data = 0; after release a new frame 0x20..0x27 drains as 0x20,0x24,... starting at out_idx 0.
- Back-to-back frames with random in_valid and out_ready gaps over 50 frames: a scoreboard matches every frame in bit-reversed order.
